// File: rtl/gray_tracker_pkg.sv
// Shared types, default parameters and Gray-to-binary helper for the gray tracker.
package gray_pkg;

   typedef enum logic [1:0] {INIT, TRACK, FAULT} trk_state_t;

   localparam int W_DEF      = 3;
   localparam int POS_W_DEF  = 8;
   localparam int ERR_W_DEF  = 4;
   localparam int LOCK_N_DEF = 4;
   localparam int MAX_W      = 8;

   // bin[i] is the XOR of all Gray bits from the MSB down to bit i.
   function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g, input int w);
      logic [MAX_W-1:0] mask;
      logic [MAX_W-1:0] gm;
      logic [MAX_W-1:0] b;
      mask = '1;
      mask = mask >> (MAX_W - w);
      gm   = g & mask;
      b    = '0;
      for (int i = 0; i < MAX_W; i++) begin
         b[i] = ^(gm >> i);
      end
      return b;
   endfunction

endpackage

// File: rtl/gray_tracker_if.sv
// Signal bundle between the Gray source / consumer and the tracker core.
interface gray_tracker_if #(
   parameter int W     = gray_pkg::W_DEF,
   parameter int POS_W = gray_pkg::POS_W_DEF,
   parameter int ERR_W = gray_pkg::ERR_W_DEF
);
   logic [W-1:0]     g;
   logic             clr;
   logic [W-1:0]     bin;
   logic [POS_W-1:0] pos;
   logic             dir;
   logic             step;
   logic             wrap;
   logic             err;
   logic [ERR_W-1:0] err_cnt;
   logic             locked;

   modport master (
      output g, clr,
      input  bin, pos, dir, step, wrap, err, err_cnt, locked
   );

   modport slave (
      input  g, clr,
      output bin, pos, dir, step, wrap, err, err_cnt, locked
   );
endinterface

// File: rtl/gray_tracker_gray2bin_w.sv
// Combinational W-bit Gray-to-binary converter.
module gray2bin_w
   import gray_pkg::*;
#(
   parameter int W = W_DEF
) (
   input  logic [W-1:0] g,
   output logic [W-1:0] b
);

   assign b = W'(gray2bin(MAX_W'(g), W));

endmodule

// File: rtl/gray_tracker.sv
// Gray-code position tracker with step classification and lock FSM.
// Optional GRAY_TRACKER_SYNC_EN adds a two-flop input synchronizer.
module gray_tracker
   import gray_pkg::*;
#(
   parameter int W      = W_DEF,
   parameter int POS_W  = POS_W_DEF,
   parameter int ERR_W  = ERR_W_DEF,
   parameter int LOCK_N = LOCK_N_DEF
) (
   input logic           clk,
   input logic           rst_n,
   gray_tracker_if.slave bus
);

   localparam logic [W-1:0] ONE_W     = W'(1);
   localparam logic [W-1:0] TOP_W     = '1;
   localparam logic [3:0]   GOOD_LAST = 4'(LOCK_N - 1);

   function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
      return (v == '1) ? v : v + ERR_W'(1);
   endfunction

   logic [W-1:0] g_s;

`ifdef GRAY_TRACKER_SYNC_EN
   logic [W-1:0] g_p0;
   logic [W-1:0] g_p1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         g_p0 <= '0;
         g_p1 <= '0;
      end else begin
         g_p0 <= bus.g;
         g_p1 <= g_p0;
      end
   end

   assign g_s = g_p1;
`else
   assign g_s = bus.g;
`endif

   logic [W-1:0] b;

   gray2bin_w #(.W(W)) u_conv (
      .g (g_s),
      .b (b)
   );

   trk_state_t       state;
   logic [W-1:0]     ref_bin;
   logic [3:0]       good_cnt;
   logic [W-1:0]     bin_q;
   logic [POS_W-1:0] pos_q;
   logic             dir_q;
   logic             step_q;
   logic             wrap_q;
   logic             err_q;
   logic [ERR_W-1:0] err_cnt_q;
   logic             locked_q;

   logic is_up;
   logic is_dn;
   logic is_hold;
   logic is_bad;

   always_comb begin
      is_hold = (b == ref_bin);
      is_up   = (b == ref_bin + ONE_W);
      is_dn   = (b == ref_bin - ONE_W);
      is_bad  = !(is_hold || is_up || is_dn);
   end

   // Sample stage: classification against ref_bin updates all state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= INIT;
         ref_bin   <= '0;
         good_cnt  <= '0;
         bin_q     <= '0;
         pos_q     <= '0;
         dir_q     <= 1'b1;
         step_q    <= 1'b0;
         wrap_q    <= 1'b0;
         err_q     <= 1'b0;
         err_cnt_q <= '0;
         locked_q  <= 1'b0;
      end else begin
         bin_q  <= b;
         step_q <= 1'b0;
         wrap_q <= 1'b0;
         err_q  <= 1'b0;
         if (bus.clr) begin
            pos_q     <= '0;
            err_cnt_q <= '0;
            good_cnt  <= '0;
            ref_bin   <= b;
            state     <= TRACK;
            locked_q  <= 1'b1;
         end else begin
            case (state)
               INIT: begin
                  ref_bin  <= b;
                  state    <= TRACK;
                  locked_q <= 1'b1;
               end
               TRACK: begin
                  if (is_up) begin
                     pos_q   <= pos_q + POS_W'(1);
                     dir_q   <= 1'b1;
                     step_q  <= 1'b1;
                     wrap_q  <= (ref_bin == TOP_W);
                     ref_bin <= b;
                  end else if (is_dn) begin
                     pos_q   <= pos_q - POS_W'(1);
                     dir_q   <= 1'b0;
                     step_q  <= 1'b1;
                     wrap_q  <= (ref_bin == '0);
                     ref_bin <= b;
                  end else if (is_bad) begin
                     err_q     <= 1'b1;
                     err_cnt_q <= sat_inc(err_cnt_q);
                     ref_bin   <= b;
                     good_cnt  <= '0;
                     state     <= FAULT;
                     locked_q  <= 1'b0;
                  end
               end
               FAULT: begin
                  ref_bin <= b;
                  if (is_bad) begin
                     err_q     <= 1'b1;
                     err_cnt_q <= sat_inc(err_cnt_q);
                     good_cnt  <= '0;
                  end else if (good_cnt == GOOD_LAST) begin
                     good_cnt <= '0;
                     state    <= TRACK;
                     locked_q <= 1'b1;
                  end else begin
                     good_cnt <= good_cnt + 4'd1;
                  end
               end
               default: begin
                  state    <= INIT;
                  locked_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.bin     = bin_q;
   assign bus.pos     = pos_q;
   assign bus.dir     = dir_q;
   assign bus.step    = step_q;
   assign bus.wrap    = wrap_q;
   assign bus.err     = err_q;
   assign bus.err_cnt = err_cnt_q;
   assign bus.locked  = locked_q;

endmodule
